// File: rtl/pmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// pmem_arbiter_if
// Purpose : one physical-memory line port (request strobes, address, write
//           line, read line, completion pulse). The same bundle describes the
//           icache port, the dcache port and the memory/cacheline-adaptor port.
// Signals : read, write   request strobes (driven by the requester)
//           address       line address    (driven by the requester)
//           wdata         write-back line (driven by the requester)
//           rdata         returned line   (driven by the responder)
//           resp          completion pulse (driven by the responder)
// Modports: master - the side that issues requests (a cache, or the arbiter
//                    towards memory)
//           slave  - the side that services requests (memory, or the arbiter
//                    towards a cache)
// -----------------------------------------------------------------------------
interface pmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [LINE_W-1:0] wdata;
  logic [LINE_W-1:0] rdata;
  logic              resp;

  modport master (output read, write, address, wdata, input rdata, resp);
  modport slave  (input read, write, address, wdata, output rdata, resp);
endinterface

// File: rtl/pmem_arbiter.sv
// -----------------------------------------------------------------------------
// pmem_arbiter
// Purpose : shares the single physical-memory line port between the icache
//           (read-only line fills) and the dcache (line fills and dirty
//           write-backs). One client owns memory for a whole transaction;
//           simultaneous requests are granted round-robin, icache first after
//           reset. Every transaction is followed by one IDLE cycle so the
//           memory strobes always drop between transactions.
// Ports   : clk     system clock (posedge)
//           rst_n   asynchronous active-low reset
//           i_pmem  icache port  (slave)  - read/address in, rdata/resp out
//           d_pmem  dcache port  (slave)  - read/write/address/wdata in,
//                                           rdata/resp out
//           mem     memory port  (master) - read/write/address/wdata out,
//                                           rdata/resp in
// Option  : PMEM_ARB_PERF_EN adds saturating 32-bit counters on outputs
//           perf_i_grants, perf_d_grants (entries into each grant state) and
//           perf_conflicts (IDLE cycles with both clients requesting).
// -----------------------------------------------------------------------------
module pmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic           clk,
  input  logic           rst_n,
  pmem_arbiter_if.slave  i_pmem,
  pmem_arbiter_if.slave  d_pmem,
  pmem_arbiter_if.master mem
`ifdef PMEM_ARB_PERF_EN
  ,
  output logic [31:0]    perf_i_grants,
  output logic [31:0]    perf_d_grants,
  output logic [31:0]    perf_conflicts
`endif
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  state_t            r_state;
  logic              r_last_gnt;   // 0: icache served last, 1: dcache served last
  logic [ADDR_W-1:0] r_addr;
  logic              r_wr;
  logic [LINE_W-1:0] r_wdata;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [LINE_W-1:0] r_i_rdata;
  logic [LINE_W-1:0] r_d_rdata;

  logic w_req_i;
  logic w_req_d;
  logic w_pick_i;
  logic w_pick_d;
  logic w_i_resp;
  logic w_d_resp;
  logic w_unused;

  assign w_req_i  = i_pmem.read;
  assign w_req_d  = d_pmem.read | d_pmem.write;
  // On a tie the client that was not served last wins.
  assign w_pick_i = w_req_i & (~w_req_d | r_last_gnt);
  assign w_pick_d = w_req_d & (~w_req_i | ~r_last_gnt);

  // The icache never writes; its write-side signals are intentionally ignored.
  assign w_unused = ^{i_pmem.write, i_pmem.wdata};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_last_gnt  <= 1'b1;
      r_addr      <= '0;
      r_wr        <= 1'b0;
      r_wdata     <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // mem_resp arriving here belongs to nobody and is dropped.
          if (w_pick_i) begin
            r_state    <= GNT_I;
            r_addr     <= i_pmem.address;
            r_wr       <= 1'b0;
            r_wdata    <= '0;
            r_mem_read <= 1'b1;
          end else if (w_pick_d) begin
            // read+write together is a write-back: it must precede the refill.
            r_state     <= GNT_D;
            r_addr      <= d_pmem.address;
            r_wr        <= d_pmem.write;
            r_wdata     <= d_pmem.wdata;
            r_mem_read  <= ~d_pmem.write;
            r_mem_write <= d_pmem.write;
          end
        end
        GNT_I: begin
          if (mem.resp) begin
            r_state    <= IDLE;
            r_mem_read <= 1'b0;
            r_i_rdata  <= mem.rdata;
            r_last_gnt <= 1'b0;
          end
        end
        GNT_D: begin
          if (mem.resp) begin
            r_state     <= IDLE;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            if (!r_wr) r_d_rdata <= mem.rdata;
            r_last_gnt  <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
        end
      endcase
    end
  end

  assign mem.read    = r_mem_read;
  assign mem.write   = r_mem_write;
  assign mem.address = r_addr;
  assign mem.wdata   = r_wdata;

  // Completion is passed through in the resp cycle; the line is forwarded
  // live in that cycle and held from the register afterwards.
  assign w_i_resp     = (r_state == GNT_I) & mem.resp;
  assign w_d_resp     = (r_state == GNT_D) & mem.resp;
  assign i_pmem.resp  = w_i_resp;
  assign d_pmem.resp  = w_d_resp;
  assign i_pmem.rdata = w_i_resp ? mem.rdata : r_i_rdata;
  assign d_pmem.rdata = (w_d_resp & ~r_wr) ? mem.rdata : r_d_rdata;

`ifdef PMEM_ARB_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] r_perf_i;
  logic [31:0] r_perf_d;
  logic [31:0] r_perf_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_i <= '0;
      r_perf_d <= '0;
      r_perf_c <= '0;
    end else if (r_state == IDLE) begin
      if (w_pick_i)           r_perf_i <= sat_inc(r_perf_i);
      if (w_pick_d)           r_perf_d <= sat_inc(r_perf_d);
      if (w_req_i && w_req_d) r_perf_c <= sat_inc(r_perf_c);
    end
  end

  assign perf_i_grants  = r_perf_i;
  assign perf_d_grants  = r_perf_d;
  assign perf_conflicts = r_perf_c;
`endif

endmodule

// File: tb/tb_pmem_arbiter.sv
module tb_pmem_arbiter;

  logic clk;
  logic rst_n;

  pmem_arbiter_if #(.ADDR_W(32), .LINE_W(256)) ic ();
  pmem_arbiter_if #(.ADDR_W(32), .LINE_W(256)) dc ();
  pmem_arbiter_if #(.ADDR_W(32), .LINE_W(256)) mm ();

`ifdef PMEM_ARB_PERF_EN
  logic [31:0] perf_i_grants, perf_d_grants, perf_conflicts;
`endif

  pmem_arbiter #(.ADDR_W(32), .LINE_W(256)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_pmem (ic),
    .d_pmem (dc),
    .mem    (mm)
`ifdef PMEM_ARB_PERF_EN
    ,
    .perf_i_grants  (perf_i_grants),
    .perf_d_grants  (perf_d_grants),
    .perf_conflicts (perf_conflicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  int           lat;
  logic [255:0] rd_pattern;
  logic         force_resp;
  int           mcnt = 0;
  int           rd_cycles = 0;
  int           wr_cycles = 0;
  logic [31:0]  rd_addr = '0;
  logic [31:0]  wr_addr = '0;
  logic [255:0] wr_data = '0;

  always @(posedge clk) begin
    #1;
    if (mm.read || mm.write) begin
      mcnt++;
      if (mm.read) rd_cycles++; else wr_cycles++;
      if (mcnt == lat) begin
        mm.resp  = 1'b1;
        mm.rdata = rd_pattern;
        if (mm.write) begin
          wr_addr = mm.address;
          wr_data = mm.wdata;
        end else begin
          rd_addr = mm.address;
        end
      end else begin
        mm.resp  = 1'b0;
        mm.rdata = ~rd_pattern;
      end
    end else begin
      mcnt     = 0;
      mm.resp  = force_resp;
      mm.rdata = force_resp ? rd_pattern : ~rd_pattern;
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
  int           cmp_checks = 0;
  int           cmp_errors = 0;
  int           cyc = 0;
  int           m_owner = 0;        // 0 none, 1 icache, 2 dcache
  bit           m_last_d = 1'b1;
  logic [31:0]  m_addr = '0;
  bit           m_wr = 1'b0;
  logic [255:0] m_wdata = '0;
  logic [255:0] m_irdata = '0;
  logic [255:0] m_drdata = '0;
  string        m_log = "";
  int           n_iresp = 0;
  int           n_dresp = 0;
  int           last_i_resp_cyc = 0;
  int           last_rise_cyc = 0;
  bit           prev_strobe = 1'b0;
  bit           e_rd, e_wr, e_ir, e_dr, ri, rq;
  logic [255:0] e_irdata, e_drdata;
`ifdef PMEM_ARB_PERF_EN
  logic [31:0]  m_pi = '0, m_pd = '0, m_pc = '0;
`endif

  task automatic cmp(input string name, input logic [255:0] act, input logic [255:0] exp);
    cmp_checks++;
    if (act !== exp) begin
      cmp_errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_owner = 0; m_last_d = 1'b1; m_addr = '0; m_wr = 1'b0; m_wdata = '0;
      m_irdata = '0; m_drdata = '0;
`ifdef PMEM_ARB_PERF_EN
      m_pi = '0; m_pd = '0; m_pc = '0;
`endif
      cmp("rst_mem_read",  mm.read, 0);
      cmp("rst_mem_write", mm.write, 0);
      cmp("rst_mem_addr",  mm.address, 0);
      cmp("rst_mem_wdata", mm.wdata, 0);
      cmp("rst_i_resp",    ic.resp, 0);
      cmp("rst_d_resp",    dc.resp, 0);
      cmp("rst_i_rdata",   ic.rdata, 0);
      cmp("rst_d_rdata",   dc.rdata, 0);
    end else begin
      e_rd = (m_owner != 0) && !m_wr;
      e_wr = (m_owner != 0) && m_wr;
      e_ir = (m_owner == 1) && mm.resp;
      e_dr = (m_owner == 2) && mm.resp;
      e_irdata = e_ir ? mm.rdata : m_irdata;
      e_drdata = (e_dr && !m_wr) ? mm.rdata : m_drdata;
      cmp("mem_read",  mm.read,  e_rd);
      cmp("mem_write", mm.write, e_wr);
      cmp("i_resp",    ic.resp,  e_ir);
      cmp("d_resp",    dc.resp,  e_dr);
      cmp("i_rdata",   ic.rdata, e_irdata);
      cmp("d_rdata",   dc.rdata, e_drdata);
      if (m_owner != 0) cmp("mem_addr", mm.address, m_addr);
      if (e_wr)         cmp("mem_wdata", mm.wdata, m_wdata);
`ifdef PMEM_ARB_PERF_EN
      cmp("perf_i", perf_i_grants, m_pi);
      cmp("perf_d", perf_d_grants, m_pd);
      cmp("perf_c", perf_conflicts, m_pc);
`endif
      // ownership advances at the coming posedge
      if (m_owner != 0) begin
        if (mm.resp) begin
          if (m_owner == 1) begin
            m_irdata = mm.rdata; m_last_d = 1'b0;
          end else begin
            if (!m_wr) m_drdata = mm.rdata;
            m_last_d = 1'b1;
          end
          m_owner = 0;
        end
      end else begin
        ri = ic.read;
        rq = dc.read | dc.write;
`ifdef PMEM_ARB_PERF_EN
        if (ri && rq) m_pc = m_pc + 1;
`endif
        if (ri && (!rq || m_last_d)) begin
          m_owner = 1; m_addr = ic.address; m_wr = 1'b0; m_log = {m_log, "I"};
`ifdef PMEM_ARB_PERF_EN
          m_pi = m_pi + 1;
`endif
        end else if (rq) begin
          m_owner = 2; m_addr = dc.address; m_wr = dc.write; m_wdata = dc.wdata;
          m_log = {m_log, "D"};
`ifdef PMEM_ARB_PERF_EN
          m_pd = m_pd + 1;
`endif
        end
      end
    end
    if (ic.resp === 1'b1) begin n_iresp++; last_i_resp_cyc = cyc; end
    if (dc.resp === 1'b1) n_dresp++;
    if ((mm.read | mm.write) && !prev_strobe) last_rise_cyc = cyc;
    prev_strobe = mm.read | mm.write;
  end

  // ---------------- directed stimulus ----------------
  int n_checks = 0;
  int n_errors = 0;
  int s_rd, s_wr, s_ir, s_dr, s_log;
`ifdef PMEM_ARB_PERF_EN
  logic [31:0] s_pi, s_pd, s_pc;
`endif

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_s(input string name, input string act, input string exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
    end
  endtask

  task automatic snap();
    s_rd = rd_cycles; s_wr = wr_cycles; s_ir = n_iresp; s_dr = n_dresp; s_log = m_log.len();
  endtask

  function automatic string new_grants();
    if (m_log.len() <= s_log) return "";
    return m_log.substr(s_log, m_log.len() - 1);
  endfunction

  task automatic wait_resps(input int n, input bit drop_i, input bit drop_d, input int budget);
    int got = 0;
    int t = 0;
    while (got < n && t < budget) begin
      @(posedge clk); #2; t++;
      if (ic.resp) begin got++; if (drop_i) ic.read = 1'b0; end
      if (dc.resp) begin got++; if (drop_d) begin dc.read = 1'b0; dc.write = 1'b0; end end
    end
    chk("resp_count_in_budget", got, n);
  endtask

  task automatic wait_strobe(input bit want_wr, input int budget);
    int t = 0;
    while (!(want_wr ? mm.write : mm.read) && t < budget) begin
      @(posedge clk); #2; t++;
    end
    chk("strobe_seen", want_wr ? mm.write : mm.read, 1);
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    settle(2);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    ic.read = 0; ic.write = 0; ic.address = '0; ic.wdata = '0;
    dc.read = 0; dc.write = 0; dc.address = '0; dc.wdata = '0;
    force_resp = 1'b0; lat = 5; rd_pattern = '0;
    settle(3);
    chk("reset_mem_read", mm.read, 0);
    chk("reset_i_rdata", ic.rdata, 0);
    rst_n = 1'b1;
    settle(1);

    // 1: lone icache miss
    lat = 5; rd_pattern = {32{8'hA5}}; snap();
    ic.address = 32'h0000_1040; ic.read = 1'b1;
    wait_resps(1, 1'b1, 1'b0, 50);
    settle(3);
    chk("t1_read_cycles", rd_cycles - s_rd, 5);
    chk("t1_i_resp_pulses", n_iresp - s_ir, 1);
    chk("t1_d_resp_pulses", n_dresp - s_dr, 0);
    chk("t1_mem_addr", rd_addr, 32'h0000_1040);
    chk("t1_i_rdata_hold", ic.rdata, {32{8'hA5}});
    chk_s("t1_grants", new_grants(), "I");

    // 2: dcache write-back
    lat = 3; rd_pattern = {32{8'h3C}}; snap();
    dc.address = 32'h8000_0020; dc.wdata = {16{16'h1234}}; dc.write = 1'b1;
    wait_resps(1, 1'b0, 1'b1, 50);
    settle(3);
    chk("t2_write_cycles", wr_cycles - s_wr, 3);
    chk("t2_read_cycles", rd_cycles - s_rd, 0);
    chk("t2_wr_addr", wr_addr, 32'h8000_0020);
    chk("t2_wr_data", wr_data, {16{16'h1234}});
    chk("t2_d_resp_pulses", n_dresp - s_dr, 1);
    chk("t2_d_rdata_unchanged", dc.rdata, 0);
    chk_s("t2_grants", new_grants(), "D");

    // 3: tie after reset
    do_reset();
    lat = 4; rd_pattern = {8{32'hCAFE_0001}}; snap();
    ic.address = 32'h0000_2000; dc.address = 32'h0000_3000;
    ic.read = 1'b1; dc.read = 1'b1;
    wait_resps(2, 1'b1, 1'b1, 100);
    settle(3);
    chk_s("t3_grants", new_grants(), "ID");
    chk("t3_idle_gap", last_rise_cyc - last_i_resp_cyc, 2);
    chk("t3_d_rdata", dc.rdata, {8{32'hCAFE_0001}});
    chk("t3_d_addr", rd_addr, 32'h0000_3000);

    // 4: sustained contention
    lat = 2; rd_pattern = {4{64'h0123_4567_89AB_CDEF}}; snap();
`ifdef PMEM_ARB_PERF_EN
    s_pi = perf_i_grants; s_pd = perf_d_grants; s_pc = perf_conflicts;
`endif
    ic.address = 32'h0000_5000; dc.address = 32'h0000_6000;
    ic.read = 1'b1; dc.read = 1'b1;
    wait_resps(6, 1'b0, 1'b0, 200);
    ic.read = 1'b0; dc.read = 1'b0;
    settle(3);
    chk_s("t4_grants", new_grants(), "IDIDID");
    chk("t4_i_resp_pulses", n_iresp - s_ir, 3);
    chk("t4_d_resp_pulses", n_dresp - s_dr, 3);
`ifdef PMEM_ARB_PERF_EN
    chk("t4_perf_conflicts", perf_conflicts - s_pc, 6);
    chk("t4_perf_i", perf_i_grants - s_pi, 3);
    chk("t4_perf_d", perf_d_grants - s_pd, 3);
`endif

    // 5: icache drops its request one cycle after grant
    lat = 6; rd_pattern = {16{16'h5A5A}}; snap();
    ic.address = 32'h0000_4440; ic.read = 1'b1;
    wait_strobe(1'b0, 20);
    settle(1);
    ic.read = 1'b0;
    wait_resps(1, 1'b1, 1'b0, 50);
    settle(3);
    chk("t5_read_cycles", rd_cycles - s_rd, 6);
    chk("t5_i_resp_pulses", n_iresp - s_ir, 1);
    chk("t5_mem_read_low", mm.read, 0);
    chk_s("t5_grants", new_grants(), "I");

    // mem_resp while idle is ignored
    snap();
    rd_pattern = {16{16'hDEAD}};
    force_resp = 1'b1;
    settle(1);
    force_resp = 1'b0;
    settle(2);
    chk("idle_resp_i", n_iresp - s_ir, 0);
    chk("idle_resp_d", n_dresp - s_dr, 0);
    chk("idle_resp_i_rdata", ic.rdata, {16{16'h5A5A}});
    chk_s("idle_resp_grants", new_grants(), "");

    // dcache read+write together is a write-back
    lat = 2; snap();
    dc.address = 32'h0000_7700; dc.wdata = {8{32'hFEED_F00D}};
    dc.read = 1'b1; dc.write = 1'b1;
    wait_resps(1, 1'b0, 1'b1, 50);
    settle(3);
    chk("rw_write_cycles", wr_cycles - s_wr, 2);
    chk("rw_read_cycles", rd_cycles - s_rd, 0);
    chk("rw_wr_data", wr_data, {8{32'hFEED_F00D}});
    chk_s("rw_grants", new_grants(), "D");

    // 6: async reset during a dcache write-back
    lat = 20; snap();
    dc.address = 32'h0000_9900; dc.wdata = {8{32'h1111_2222}}; dc.write = 1'b1;
    wait_strobe(1'b1, 20);
    settle(1);
    rst_n = 1'b0;
    #1;
    chk("t6_mem_write_async", mm.write, 0);
    chk("t6_mem_read_async", mm.read, 0);
    dc.write = 1'b0;
    settle(2);
    rst_n = 1'b1;
    lat = 3; snap();
    ic.address = 32'h0000_A000; dc.address = 32'h0000_B000;
    ic.read = 1'b1; dc.read = 1'b1;
    wait_resps(1, 1'b1, 1'b1, 50);
    dc.read = 1'b0;
    settle(3);
    chk_s("t6_tie_after_reset", new_grants(), "I");
    chk("t6_d_resp_pulses", n_dresp - s_dr, 0);

    n_checks += cmp_checks;
    n_errors += cmp_errors;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
